bit_serializer: RTL and testbench

//  Upstream feed for the serial sequence detector: accepts parallel words over a valid/ready handshake.

---
 rtl/ser_pkg.sv | 14 +
 rtl/ser_bit_cnt.sv | 24 ++
 rtl/bit_serializer.sv | 88 ++++++++
 tb/tb_bit_serializer.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/ser_pkg.sv
// ser_pkg: shared FSM state encoding and width helper for the bit serializer.
package ser_pkg;
    typedef enum logic [1:0] {
        SER_IDLE  = 2'd0,
        SER_SHIFT = 2'd1,
        SER_PAR   = 2'd2
    } ser_state_t;

    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/ser_bit_cnt.sv
// ser_bit_cnt: loadable down-counter with zero flag tracking bits left in a word.
module ser_bit_cnt #(
    parameter int W        = 3,
    parameter int LOAD_VAL = 7
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    input  logic i_en,
    output logic o_is_zero
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= W'(LOAD_VAL);
        else if (i_en)
            r_cnt <= r_cnt - W'(1);
    end

    assign o_is_zero = (r_cnt == '0);
endmodule

// File: rtl/bit_serializer.sv
// bit_serializer: valid/ready parallel word in, MSB-first serial stream out, completed-word counter.
// Define SER_PARITY_EN to append an even-parity bit to every word.
module bit_serializer
    import ser_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_ser_out,
    output logic             o_ser_vld,
    output logic             o_word_done,
    output logic [CNT_W-1:0] o_words_sent
);
    localparam int CW = clog2(WIDTH);

    ser_state_t       r_state, w_next;
    logic [WIDTH-1:0] r_shreg;
    logic [CNT_W-1:0] r_words;
    logic             w_zero, w_last, w_load;

    ser_bit_cnt #(.W(CW), .LOAD_VAL(WIDTH-1)) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_load),
        .i_en     ((r_state == SER_SHIFT) && !w_zero),
        .o_is_zero(w_zero)
    );

`ifdef SER_PARITY_EN
    logic r_par;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_par <= 1'b0;
        else if (w_load)
            r_par <= ^i_data;
    end

    assign w_last    = (r_state == SER_PAR);
    assign o_ser_out = (r_state == SER_SHIFT) ? r_shreg[WIDTH-1] :
                       (r_state == SER_PAR)   ? r_par : 1'b0;
`else
    assign w_last    = (r_state == SER_SHIFT) && w_zero;
    assign o_ser_out = (r_state == SER_SHIFT) ? r_shreg[WIDTH-1] : 1'b0;
`endif

    // ready never looks at i_valid, so there is no combinational path to the serial side
    assign o_ready      = (r_state == SER_IDLE) || w_last;
    assign w_load       = i_valid && o_ready;
    assign o_ser_vld    = (r_state != SER_IDLE);
    assign o_word_done  = w_last;
    assign o_words_sent = r_words;

    always_comb begin
        w_next = r_state;
        case (r_state)
            SER_IDLE:  w_next = w_load ? SER_SHIFT : SER_IDLE;
`ifdef SER_PARITY_EN
            SER_SHIFT: w_next = w_zero ? SER_PAR : SER_SHIFT;
            SER_PAR:   w_next = w_load ? SER_SHIFT : SER_IDLE;
`else
            SER_SHIFT: w_next = (w_zero && !w_load) ? SER_IDLE : SER_SHIFT;
`endif
            default:   w_next = SER_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SER_IDLE;
            r_shreg <= '0;
            r_words <= '0;
        end else begin
            r_state <= w_next;
            if (w_load)
                r_shreg <= i_data;
            else if (r_state == SER_SHIFT)
                r_shreg <= r_shreg << 1;
            if (w_last)
                r_words <= r_words + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: randomized scoreboard bench; the driver queues each accepted word's expected frame
// and a negedge monitor compares every cycle of the serial interface against it.
module tb_bit_serializer;
    localparam int W  = 8;
    localparam int CW = 2;
`ifdef SER_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_valid = 1'b0;
    logic [W-1:0]  i_data = '0;
    logic          o_ready, o_ser_out, o_ser_vld, o_word_done;
    logic [CW-1:0] o_words_sent;

    int checks = 0;
    int failures = 0;
    logic [1:0] exp_q[$];
    int cnt_model = 0;

    bit_serializer #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_data      (i_data),
        .o_ser_out   (o_ser_out),
        .o_ser_vld   (o_ser_vld),
        .o_word_done (o_word_done),
        .o_words_sent(o_words_sent)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s t=%0t {vld,out,done,ready,words}: got %b required %b", name, $time, act, req);
        end
    endtask

    // monitor: expected frame bits are {done, bit}; an empty queue means the line must be idle
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            cnt_model = 0;
        end else if (exp_q.size() > 0) begin
            logic [1:0] e;
            e = exp_q.pop_front();
            check("frame_bit", {o_ser_vld, o_ser_out, o_word_done, o_ready, o_words_sent},
                  {1'b1, e[0], e[1], e[1], CW'(cnt_model)});
            if (e[1]) cnt_model = (cnt_model + 1) % (1 << CW);
        end else begin
            check("idle", {o_ser_vld, o_ser_out, o_word_done, o_ready, o_words_sent},
                  {4'b0001, CW'(cnt_model)});
        end
    end

    task automatic push_frame(input logic [W-1:0] w);
        for (int i = W - 1; i >= 0; i--)
            exp_q.push_back({(i == 0) && !PAR, w[i]});
        if (PAR) exp_q.push_back({1'b1, ^w});
    endtask

    // offers w until accepted; with scramble, in_data is changed every stalled cycle
    task automatic send(input logic [W-1:0] w, input bit scramble);
        bit hs;
        int k;
        i_valid = 1'b1;
        i_data  = w;
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            hs = o_ready;
            @(posedge clk);
            #1;
            if (hs) begin
                push_frame(i_data);
                break;
            end
            if (scramble) i_data = W'($urandom);
        end
        if (k == 100) begin
            checks++;
            failures++;
            $display("FAIL handshake_timeout word %h never accepted", w);
        end
    endtask

    task automatic idle(input int n);
        i_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int k = 0;
        i_valid = 1'b0;
        while (exp_q.size() > 0 && k < 60) begin
            @(posedge clk);
            k++;
        end
        #1;
        checks++;
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain %0d expected bits never appeared, required 0", exp_q.size());
        end
    endtask

    task automatic do_reset();
        i_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("reset_immediate", {o_ser_vld, o_ser_out, o_word_done, o_ready, o_words_sent},
              {4'b0001, CW'(0)});
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("reset_release", {o_ser_vld, o_ser_out, o_word_done, o_ready, o_words_sent},
              {4'b0001, CW'(0)});
    endtask

    initial begin
        #1;
        check("reset_at_start", {o_ser_vld, o_ser_out, o_word_done, o_ready, o_words_sent},
              {4'b0001, CW'(0)});
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);
        // single word and back-to-back words with in_valid held
        send(8'hE0, 1'b0);
        idle(3);
        send(8'hFF, 1'b0);
        send(8'h0F, 1'b0);
        drain();
        idle(2);
        // stalled offer with in_data scrambled until the final bit cycle
        send(8'h3C, 1'b0);
        send(8'h5A, 1'b1);
        drain();
        // reset on the 3rd bit of a word
        idle(1);
        send(8'hA5, 1'b0);
        i_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        // counter wrap over five words, plus parity-relevant patterns
        send(8'h07, 1'b0);
        send(8'h03, 1'b0);
        send(8'h00, 1'b0);
        send(8'h80, 1'b0);
        send(8'h01, 1'b0);
        drain();
        idle(2);
        for (int n = 0; n < 40; n++) begin
            int gap;
            gap = $urandom_range(0, 3);
            if (gap > 0 && $urandom_range(0, 1) == 1) idle(gap);
            send(W'($urandom), $urandom_range(0, 1) == 1);
        end
        drain();
        idle(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
